// File: rtl/cbfp_stage21.sv
// cbfp_stage21: block-floating-point normaliser between the stage-20 twiddle
// multiply and the stage-21 butterfly. Each group of GROUP_BEATS 16-lane beats
// is buffered, its common headroom found, and the group is re-emitted shifted
// left by that headroom and narrowed to OUT_WIDTH, with the shift on dout_exp.
// Optional build macro: CBFP_ROUND_EN selects round-half-up with saturation
// for the narrowing step; without it the LSB is simply truncated.
module cbfp_stage21 #(
  parameter int IN_WIDTH    = 13,
  parameter int OUT_WIDTH   = 12,
  parameter int GROUP_BEATS = 2,
  parameter int MAX_SHIFT   = 12
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic signed [IN_WIDTH-1:0]  din_re [16],
  input  logic signed [IN_WIDTH-1:0]  din_im [16],
  input  logic                        din_valid,
  output logic signed [OUT_WIDTH-1:0] dout_re [16],
  output logic signed [OUT_WIDTH-1:0] dout_im [16],
  output logic                        dout_valid,
  output logic                        dout_first,
  output logic [3:0]                  dout_exp
);

  localparam int CW = $clog2(GROUP_BEATS);
  localparam logic [CW-1:0] LAST_BEAT = CW'(GROUP_BEATS - 1);
  localparam logic [3:0] RSB_MAX   = 4'(IN_WIDTH - 1);
  localparam logic [3:0] SHIFT_MAX = 4'(MAX_SHIFT);

  // Ping-pong sample storage and the headroom latched with each buffer
  logic signed [IN_WIDTH-1:0] buf_re [2][GROUP_BEATS][16];
  logic signed [IN_WIDTH-1:0] buf_im [2][GROUP_BEATS][16];
  logic [3:0]                 grp_m  [2];

  logic [CW-1:0] wr_cnt;
  logic          wr_sel;
  logic [3:0]    run_min;
  logic [3:0]    beat_min;
  logic          wr_last;

  logic [CW-1:0] rd_cnt;
  logic          rd_sel;
  logic [1:0]    full;
  logic          rd_go;
  logic          rd_last;
  logic [3:0]    rd_s;

  logic signed [OUT_WIDTH-1:0] nxt_re [16];
  logic signed [OUT_WIDTH-1:0] nxt_im [16];

  // Redundant sign bits: leading bits equal to the sign bit, not counting the sign itself
  function automatic logic [3:0] rsb(input logic signed [IN_WIDTH-1:0] x);
    logic [3:0] n;
    logic       run;
    n   = '0;
    run = 1'b1;
    for (int b = IN_WIDTH - 2; b >= 0; b--) begin
      if (run && (x[b] == x[IN_WIDTH-1])) n = n + 4'd1;
      else run = 1'b0;
    end
    return n;
  endfunction

  // Drop one LSB after the headroom shift
  function automatic logic signed [OUT_WIDTH-1:0] narrow(input logic signed [IN_WIDTH-1:0] y);
`ifdef CBFP_ROUND_EN
    localparam logic signed [IN_WIDTH:0] Y_MAX = (IN_WIDTH+1)'((1 << (IN_WIDTH - 1)) - 1);
    logic signed [IN_WIDTH:0] t;
    t = {y[IN_WIDTH-1], y};
    t = t + (IN_WIDTH+1)'(1);
    if (t > Y_MAX) t = Y_MAX;
    return OUT_WIDTH'(t >>> 1);
`else
    return OUT_WIDTH'(y >>> 1);
`endif
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] scale_narrow(input logic signed [IN_WIDTH-1:0] x,
                                                               input logic [3:0] s);
    logic signed [IN_WIDTH-1:0] y;
    y = x <<< s;
    return narrow(y);
  endfunction

  assign wr_last = din_valid && (wr_cnt == LAST_BEAT);
  assign rd_go   = full[rd_sel];
  assign rd_last = rd_go && (rd_cnt == LAST_BEAT);
  assign rd_s    = (grp_m[rd_sel] < SHIFT_MAX) ? grp_m[rd_sel] : SHIFT_MAX;

  // Fold the headroom of every sample in the incoming beat into the running minimum
  always_comb begin
    logic [3:0] r;
    beat_min = run_min;
    for (int l = 0; l < 16; l++) begin
      r = rsb(din_re[l]);
      if (r < beat_min) beat_min = r;
      r = rsb(din_im[l]);
      if (r < beat_min) beat_min = r;
    end
  end

  // Write side: beat counter, buffer select and running minimum across the group
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_cnt  <= '0;
      wr_sel  <= 1'b0;
      run_min <= RSB_MAX;
    end else if (din_valid) begin
      if (wr_last) begin
        wr_cnt  <= '0;
        wr_sel  <= ~wr_sel;
        run_min <= RSB_MAX;
      end else begin
        wr_cnt  <= wr_cnt + 1'b1;
        run_min <= beat_min;
      end
    end
  end

  // Capture valid beats into the active buffer; the group headroom lands with the last beat
  always_ff @(posedge clk) begin
    if (din_valid) begin
      for (int l = 0; l < 16; l++) begin
        buf_re[wr_sel][wr_cnt][l] <= din_re[l];
        buf_im[wr_sel][wr_cnt][l] <= din_im[l];
      end
      if (wr_last) grp_m[wr_sel] <= beat_min;
    end
  end

  // Read side: drain a full buffer on consecutive cycles, then hand over to the other one
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_cnt <= '0;
      rd_sel <= 1'b0;
      full   <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (wr_last && (wr_sel == 1'(i))) full[i] <= 1'b1;
        else if (rd_last && (rd_sel == 1'(i))) full[i] <= 1'b0;
      end
      if (rd_go) begin
        rd_cnt <= rd_last ? '0 : rd_cnt + 1'b1;
        if (rd_last) rd_sel <= ~rd_sel;
      end
    end
  end

  // Shift the beat being read by the group exponent and narrow it
  always_comb begin
    for (int l = 0; l < 16; l++) begin
      nxt_re[l] = scale_narrow(buf_re[rd_sel][rd_cnt][l], rd_s);
      nxt_im[l] = scale_narrow(buf_im[rd_sel][rd_cnt][l], rd_s);
    end
  end

  // Registered outputs; samples and exponent hold while no beat is emitted
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int l = 0; l < 16; l++) begin
        dout_re[l] <= '0;
        dout_im[l] <= '0;
      end
      dout_valid <= 1'b0;
      dout_first <= 1'b0;
      dout_exp   <= '0;
    end else begin
      dout_valid <= rd_go;
      dout_first <= rd_go && (rd_cnt == '0);
      if (rd_go) begin
        for (int l = 0; l < 16; l++) begin
          dout_re[l] <= nxt_re[l];
          dout_im[l] <= nxt_im[l];
        end
        dout_exp <= rd_s;
      end
    end
  end

endmodule
